// File: rtl/axis_rom_stream_arbiter.sv
// axis_rom_stream_arbiter: grants per-requester ROM read jobs and streams the words out with backpressure.
// Define AXIS_ROM_ARB_FIXED_PRIO_EN for fixed-priority grant; round-robin otherwise.
module axis_rom_stream_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int DEPTH              = 33,
    parameter int WIDTH              = 32,
    parameter int ROM_MEMORY_LATENCY = 2,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1),
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      busy,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [WIDTH-1:0]          rom_dout,
    input  logic                      ds_next_data,
    output logic [WIDTH-1:0]          ds_out,
    output logic                      ds_valid,
    output logic                      ds_last,
    output logic [ID_W-1:0]           ds_id
);
    localparam int L  = ROM_MEMORY_LATENCY;
    localparam int FD = L + 1;
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state, state_nxt;

    logic [NUM_REQ-1:0] pending;
    logic [ADDR_W-1:0]  slot_base [NUM_REQ];
    logic [LEN_W-1:0]   slot_len  [NUM_REQ];
    logic [ID_W-1:0]    rr_ptr, gnt, idx, id;
    logic               gnt_vld, arb, pop;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   len, issued, xfers;
    logic [L-1:0]       pipe;
    logic [WIDTH-1:0]   fifo [FD];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      fifo_cnt, inflight;

    // Search from rr_ptr upward; the lowest offset with a pending bit wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (pending[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < L; k++) inflight = inflight + CW'(pipe[k]);
    end

    // A word popped this cycle frees its slot in time for a new read, keeping full rate.
    assign arb      = state == IDLE && gnt_vld && req_done == '0;
    assign ds_valid = fifo_cnt != '0;
    assign pop      = ds_valid && ds_next_data;
    assign rom_en   = state == STREAM && (int'(inflight) + int'(fifo_cnt) - int'(pop) < FD);
    assign rom_addr = rom_en ? cur_addr : '0;
    assign ds_last  = ds_valid && xfers == len - 1'b1;
    assign ds_out   = ds_valid ? fifo[rd_ptr] : '0;
    assign ds_id    = id;
    assign busy     = state != IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb && slot_len[gnt] != '0) state_nxt = STREAM;
            STREAM:  if (rom_en && issued == len - 1'b1) state_nxt = DRAIN;
            DRAIN:   if (pop && ds_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            rr_ptr   <= '0;
            id       <= '0;
            len      <= '0;
            issued   <= '0;
            xfers    <= '0;
            cur_addr <= '0;
            pipe     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            req_done <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_base[i] <= '0;
                slot_len[i]  <= '0;
            end
        end else begin
            req_done <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_start[i] && !pending[i]) begin
                    pending[i]   <= 1'b1;
                    slot_base[i] <= req_base[i*ADDR_W +: ADDR_W];
                    slot_len[i]  <= req_len[i*LEN_W +: LEN_W];
                end
            end
            if (arb) begin
                id       <= gnt;
                len      <= slot_len[gnt];
                cur_addr <= slot_base[gnt];
                issued   <= '0;
                xfers    <= '0;
`ifdef AXIS_ROM_ARB_FIXED_PRIO_EN
                rr_ptr   <= '0;
`else
                rr_ptr   <= ID_W'((int'(gnt) + 1) % NUM_REQ);
`endif
                if (slot_len[gnt] == '0) begin
                    req_done[gnt] <= 1'b1;
                    pending[gnt]  <= 1'b0;
                end
            end
            if (state == DRAIN && pop && ds_last) begin
                req_done[id] <= 1'b1;
                pending[id]  <= 1'b0;
            end
            if (rom_en) begin
                cur_addr <= (cur_addr == ADDR_W'(DEPTH - 1)) ? '0 : cur_addr + 1'b1;
                issued   <= issued + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FD - 1)) ? '0 : rd_ptr + 1'b1;
                xfers  <= xfers + 1'b1;
            end
            if (pipe[L-1]) wr_ptr <= (wr_ptr == PW'(FD - 1)) ? '0 : wr_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(pipe[L-1]) - CW'(pop);
            pipe     <= L'({pipe, rom_en});
        end
    end

    always_ff @(posedge clk) begin
        if (pipe[L-1]) fifo[wr_ptr] <= rom_dout;
    end
endmodule

// File: tb/tb_axis_rom_stream_arbiter.sv
// tb_axis_rom_stream_arbiter: directed scenario tasks against a latency-2 ROM model.
module tb_axis_rom_stream_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_start = '0;
    logic [11:0] req_base = '0;
    logic [11:0] req_len = '0;
    logic [1:0]  req_done;
    logic        busy, rom_en, ds_valid, ds_last;
    logic [5:0]  rom_addr;
    logic [31:0] rom_dout = '0;
    logic [31:0] rom_q = '0;
    logic        ds_next_data = 1'b0;
    logic [31:0] ds_out;
    logic        ds_id;

    int checks = 0, errors = 0, cyc = 0, s_cyc = 0, maxf = 0;
    int en_addr[$], en_cyc[$], x_id[$], x_cyc[$], d_val[$], d_cyc[$];
    logic [31:0] x_data[$];
    bit x_last[$];

    axis_rom_stream_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_start(req_start), .req_base(req_base), .req_len(req_len),
        .req_done(req_done), .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .ds_next_data(ds_next_data), .ds_out(ds_out), .ds_valid(ds_valid), .ds_last(ds_last), .ds_id(ds_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int a);
        return 32'(a) * 32'h01030507 + 32'hC0DE0011;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_q <= rom_word(int'(rom_addr));
        rom_dout <= rom_q;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_en) begin en_addr.push_back(int'(rom_addr)); en_cyc.push_back(cyc); end
            if (ds_valid && ds_next_data) begin
                x_data.push_back(ds_out); x_last.push_back(ds_last);
                x_id.push_back(int'(ds_id)); x_cyc.push_back(cyc);
            end
            if (req_done != 2'b00) begin d_val.push_back(int'(req_done)); d_cyc.push_back(cyc); end
            if (int'(dut.fifo_cnt) > maxf) maxf = int'(dut.fifo_cnt);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear();
        en_addr.delete(); en_cyc.delete(); x_data.delete(); x_last.delete();
        x_id.delete(); x_cyc.delete(); d_val.delete(); d_cyc.delete(); maxf = 0;
    endtask

    task automatic start(input int i, input int base, input int len);
        req_start[i] = 1'b1;
        req_base[i*6 +: 6] = 6'(base);
        req_len[i*6 +: 6] = 6'(len);
        s_cyc = cyc;
        tick();
        req_start = '0;
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int b = 0;
        while (d_val.size() < n && b < budget) begin tick(); b++; end
        checks++;
        if (d_val.size() < n) begin errors++; $display("FAIL %s_timeout dones=%0d want %0d", name, d_val.size(), n); end
        repeat (3) tick();
    endtask

    task automatic check_stream(input string name, input int base, input int len, input int id);
        checks++;
        if (x_data.size() != len) begin errors++; $display("FAIL %s_count got %0d want %0d", name, x_data.size(), len); end
        checks++;
        if (en_addr.size() != len) begin errors++; $display("FAIL %s_reads got %0d want %0d", name, en_addr.size(), len); end
        for (int k = 0; k < len && k < x_data.size(); k++) begin
            checks++;
            if (x_data[k] !== rom_word((base + k) % 33) || x_last[k] !== (k == len - 1) || x_id[k] != id) begin
                errors++;
                $display("FAIL %s_word%0d got %h/%0d/%0d want %h/%0d/%0d", name, k, x_data[k], x_last[k], x_id[k],
                         rom_word((base + k) % 33), k == len - 1, id);
            end
        end
        for (int k = 0; k < len && k < en_addr.size(); k++) begin
            checks++;
            if (en_addr[k] != (base + k) % 33) begin errors++; $display("FAIL %s_addr%0d got %0d want %0d", name, k, en_addr[k], (base + k) % 33); end
        end
        checks++;
        if (d_val.size() == 0 || d_val[0] != (1 << id)) begin errors++; $display("FAIL %s_done got %0d want %0d", name, d_val.size() ? d_val[0] : 0, 1 << id); end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rom_en, rom_addr, ds_valid, ds_last, ds_out, ds_id, req_done, busy} !== '0) begin
            errors++; $display("FAIL reset_during got %h want 0", {rom_en, rom_addr, ds_valid, ds_last, ds_out, ds_id, req_done, busy});
        end
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rom_en, rom_addr, ds_valid, ds_last, ds_out, ds_id, req_done, busy} !== '0) begin
            errors++; $display("FAIL reset_after got %h want 0", {rom_en, rom_addr, ds_valid, ds_last, ds_out, ds_id, req_done, busy});
        end
    endtask

    task automatic test_single();
        clear();
        ds_next_data = 1'b1;
        start(0, 0, 33);
        wait_dones(1, 200, "single");
        check_stream("single", 0, 33, 0);
        if (x_cyc.size() == 33 && en_cyc.size() > 0) begin
            checks++;
            if (x_cyc[0] - en_cyc[0] != 3) begin errors++; $display("FAIL single_latency got %0d want 3", x_cyc[0] - en_cyc[0]); end
            checks++;
            if (x_cyc[32] - x_cyc[0] != 32) begin errors++; $display("FAIL single_rate got %0d want 32", x_cyc[32] - x_cyc[0]); end
            checks++;
            if (d_cyc.size() == 0 || d_cyc[0] - x_cyc[32] != 1) begin errors++; $display("FAIL single_done_cycle got %0d want 1", d_cyc.size() ? d_cyc[0] - x_cyc[32] : -1); end
        end
    endtask

    task automatic test_backpressure();
        bit held = 0;
        logic [31:0] hd = '0;
        logic hl = 1'b0, hi = 1'b0;
        int b = 0, maxgap = 0;
        clear();
        start(0, 0, 33);
        while (d_val.size() < 1 && b < 300) begin
            ds_next_data = ~ds_next_data;
            @(negedge clk);
            if (held) begin
                checks++;
                if (!ds_valid || ds_out !== hd || ds_last !== hl || ds_id !== hi) begin
                    errors++; $display("FAIL bp_hold got %0d/%h/%0d want 1/%h/%0d", ds_valid, ds_out, ds_last, hd, hl);
                end
            end
            held = ds_valid && !ds_next_data;
            hd = ds_out; hl = ds_last; hi = ds_id;
            tick();
            b++;
        end
        ds_next_data = 1'b1;
        checks++;
        if (d_val.size() < 1) begin errors++; $display("FAIL bp_timeout dones=0 want 1"); end
        repeat (3) tick();
        check_stream("bp", 0, 33, 0);
        for (int k = 1; k < x_cyc.size(); k++) if (x_cyc[k] - x_cyc[k-1] > maxgap) maxgap = x_cyc[k] - x_cyc[k-1];
        checks++;
        if (maxgap > 2) begin errors++; $display("FAIL bp_gap got %0d want <=2", maxgap); end
        checks++;
        if (maxf > 3) begin errors++; $display("FAIL bp_fifo got %0d want <=3", maxf); end
    endtask

    task automatic test_round_robin();
        int b = 0, nres = 0;
`ifdef AXIS_ROM_ARB_FIXED_PRIO_EN
        int exp[6] = '{1, 1, 1, 1, 1, 2};
`else
        int exp[6] = '{1, 2, 1, 2, 1, 2};
`endif
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
        clear();
        req_base = {6'd10, 6'd0};
        req_len = {6'd4, 6'd4};
        req_start = 2'b11;
        tick();
        req_start = '0;
        while (d_val.size() < 6 && b < 400) begin
            @(negedge clk);
            if (req_done != 2'b00 && nres < 4) begin req_start = req_done; nres++; end
            tick();
            req_start = '0;
            b++;
        end
        checks++;
        if (d_val.size() < 6) begin errors++; $display("FAIL rr_timeout dones=%0d want 6", d_val.size()); end
        for (int k = 0; k < 6 && k < d_val.size(); k++) begin
            checks++;
            if (d_val[k] != exp[k]) begin errors++; $display("FAIL rr_order%0d got %0d want %0d", k, d_val[k], exp[k]); end
        end
        for (int k = 0; k < 24 && k < x_data.size(); k++) begin
            checks++;
            if (x_id[k] != exp[k/4] - 1 || x_data[k] !== rom_word((exp[k/4] == 2 ? 10 : 0) + k % 4)) begin
                errors++; $display("FAIL rr_word%0d got %0d/%h want %0d/%h", k, x_id[k], x_data[k], exp[k/4] - 1, rom_word((exp[k/4] == 2 ? 10 : 0) + k % 4));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_wrap_zero();
        clear();
        start(1, 30, 5);
        wait_dones(1, 100, "wrap");
        check_stream("wrap", 30, 5, 1);
        clear();
        start(0, 5, 0);
        wait_dones(1, 20, "zero");
        checks++;
        if (d_val.size() == 0 || d_val[0] != 1 || d_cyc[0] - s_cyc != 2) begin
            errors++; $display("FAIL zero_done got %0d@%0d want 1@2", d_val.size() ? d_val[0] : 0, d_cyc.size() ? d_cyc[0] - s_cyc : -1);
        end
        checks++;
        if (en_addr.size() != 0 || x_data.size() != 0) begin errors++; $display("FAIL zero_traffic got %0d/%0d want 0/0", en_addr.size(), x_data.size()); end
    endtask

    task automatic test_reset_mid();
        int b = 0;
        clear();
        start(0, 3, 33);
        while (x_data.size() < 11 && b < 100) begin tick(); b++; end
        checks++;
        if (x_data.size() < 11) begin errors++; $display("FAIL mid_timeout words=%0d want 11", x_data.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, rom_addr, ds_valid, ds_last, ds_out, ds_id, req_done, busy} !== '0) begin
            errors++; $display("FAIL mid_reset_out got %h want 0", {rom_en, rom_addr, ds_valid, ds_last, ds_out, ds_id, req_done, busy});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({ds_valid, rom_en, busy, req_done} !== '0) begin errors++; $display("FAIL mid_quiet%0d got %b want 0", k, {ds_valid, rom_en, busy, req_done}); end
            tick();
        end
        checks++;
        if (d_val.size() != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", d_val.size()); end
        clear();
        start(1, 20, 4);
        wait_dones(1, 100, "mid_next");
        check_stream("mid_next", 20, 4, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_wrap_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/axis_rom_stream_arbiter.md
AXIS_ROM_STREAM_ARBITER -- requirements
Module: axis_rom_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DEPTH, default 33, ROM words.
REQ-003 SHALL have parameter WIDTH, default 32, ROM word width.
REQ-004 SHALL have parameter ROM_MEMORY_LATENCY (L), default 2, cycles from rom_en to valid rom_dout.
REQ-005 SHALL derive ADDR_W = $clog2(DEPTH) and LEN_W = $clog2(DEPTH+1).
REQ-006 Ports SHALL be:
 clk  in  1  clock, one clock domain.
 rst_n  in  1  asynchronous reset, active-low.
 req_start  in  NUM_REQ  per-requester one-cycle start pulse.
 req_base  in  NUM_REQ*ADDR_W  start address per requester, sampled on its start pulse.
 req_len  in  NUM_REQ*LEN_W  word count per requester, sampled on its start pulse.
 req_done  out  NUM_REQ  one-cycle pulse when that requester's stream completes.
 busy  out  1  high outside IDLE.
 rom_en  out  1  ROM read enable.
 rom_addr  out  ADDR_W  ROM read address.
 rom_dout  in  WIDTH  ROM data, valid L cycles after rom_en.
 ds_next_data  in  1  downstream ready.
 ds_out  out  WIDTH  stream data.
 ds_valid  out  1  stream valid.
 ds_last  out  1  final word of current stream.
 ds_id  out  $clog2(NUM_REQ)  requester index owning current stream.

Function
REQ-007 SHALL latch base/len into a per-requester slot and set pending[i] on req_start[i]; a start while pending[i] is already set SHALL be ignored.
REQ-008 FSM SHALL have states IDLE, STREAM, DRAIN; IDLE->STREAM on any pending bit, granting one requester per REQ-009.
REQ-009 Grant SHALL be round-robin: search starts at index after last granted, wraps at NUM_REQ; after reset search starts at 0.
REQ-010 In STREAM, rom_en SHALL assert on each cycle where outstanding reads plus output-FIFO occupancy < L+1, rom_addr = (base + k) mod DEPTH for issued word k.
REQ-011 Returned rom_dout SHALL enter an L+1-entry output FIFO; no word SHALL be dropped or duplicated under any ds_next_data pattern.
REQ-012 STREAM->DRAIN when all len reads are issued; DRAIN->IDLE on the transfer (ds_valid && ds_next_data) carrying ds_last.
REQ-013 First ds_valid SHALL assert L+1 cycles after first rom_en; with ds_next_data held high throughput SHALL be one word per cycle.
REQ-014 ds_out/ds_last/ds_id SHALL hold stable while ds_valid && !ds_next_data.
REQ-015 ds_last SHALL be high only with word len-1 of the granted stream.
REQ-016 req_done[id] SHALL pulse in the cycle after the last transfer; pending[id] cleared the same cycle; FSM in IDLE that cycle, re-arbitrating next cycle.
REQ-017 A req_len of 0 SHALL produce no rom_en and no ds_valid; grant proceeds straight to req_done pulse next cycle.
REQ-018 req_start[i] coincident with req_done[i] SHALL re-set pending[i] with new base/len.
REQ-019 Addresses SHALL wrap mod DEPTH when base+len > DEPTH.

Reset
REQ-020 rst_n low SHALL asynchronously clear pending, FIFO, counters, round-robin pointer; FSM to IDLE.
REQ-021 During reset and after: rom_en=0, rom_addr=0, ds_valid=0, ds_last=0, ds_out=0, ds_id=0, req_done=0, busy=0.
REQ-022 Reset mid-stream SHALL abandon the stream with no req_done; data arriving from in-flight reads after reset release SHALL be discarded.

Configuration
REQ-023 With AXIS_ROM_ARB_FIXED_PRIO_EN defined, grant SHALL be fixed-priority (lowest index wins); undefined, round-robin per REQ-009.

Verification
REQ-024 Single stream: req 0 base=0 len=33, ds_next_data=1 -> 33 words equal ROM[0..32], ds_valid 3 cycles after first rom_en, ds_last only on word 32, req_done[0] one cycle after.
REQ-025 Backpressure: ds_next_data toggling 1/0 each cycle, len=33 -> identical word sequence, no stall longer than ready-low, FIFO never exceeds 3 entries.
REQ-026 Round-robin: req 0 and 1 start same cycle, len=4 each, both restart on done -> grant order 0,1,0,1; with AXIS_ROM_ARB_FIXED_PRIO_EN -> 0,0,0,... while 0 re-requests.
REQ-027 Wrap/zero: base=30 len=5 -> addresses 30,31,32,0,1; len=0 -> req_done with no ds_valid.
REQ-028 Reset mid-stream: rst_n low after word 10 of 33 -> outputs zero immediately, no req_done, next start streams from its own base cleanly.
